muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle RV32M execute unit: radix-4 Booth multiplier plus an optional restoring divider. Sits beside the EXE-stage ALU. It accepts one M-extension operation at a time and returns the result with a one-cycle `ready` pulse. `ready` feeds the hazard unit's `ready` input, and `busy` drives the pipeline stall while an operation is in flight.

## Interface

Parameters:
- `XLEN`, 32: operand and result width. Only 32 is supported.

Ports:
- `clk`, in, 1: clock. Single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: launch an operation. Sampled only in IDLE.
- `kill`, in, 1: abort the operation in flight. Driven by the EXE flush.
- `op`, in, 3: funct3 of the M instruction: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
- `rs1`, in, 32: operand A / dividend.
- `rs2`, in, 32: operand B / divisor.
- `waddr_in`, in, 5: destination register.
- `busy`, out, 1: high from the cycle after accept until `ready` has been issued. Low otherwise.
- `ready`, out, 1: one-cycle pulse; `result` and `waddr_out` are valid in that cycle.
- `result`, out, 32: operation result. Holds its value until the next accept.
- `waddr_out`, out, 5: destination captured at accept.

## Operation

- Reset values: state=IDLE, `busy`=0, `ready`=0, `result`=0, `waddr_out`=0, all internal registers 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE, `start`=1, `kill`=0: capture `op`, `rs1`, `rs2`, `waddr_in`, then branch:
  - MUL-class op: go to MUL.
  - DIV-class op with divisor 0 or signed overflow: go directly to DONE.
  - Other DIV-class op: go to DIV.
- `start` while not IDLE is ignored. No queueing.
- MUL:
  - Operands are extended to 34 bits: sign-extend rs1 for MUL/MULH/MULHSU, rs2 for MUL/MULH; zero-extend otherwise.
  - 17 radix-4 Booth iterations, each retiring 2 multiplier bits into a 68-bit product accumulator.
  - Result is product[31:0] for MUL and product[63:32] for MULH, MULHSU and MULHU.
- DIV:
  - Take magnitudes for signed ops, then run 32 restoring iterations (one quotient bit per cycle).
  - Sign fixups: quotient is negated when operand signs differ; remainder takes the dividend's sign.
- Special cases, per the RISC-V spec:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = rs1.
  - DIV/REM of 0x80000000 by -1: quotient = 0x80000000, remainder = 0.
- DONE: assert `ready` and load `result`, then return to IDLE next cycle.
- `kill`=1 in any state: go to IDLE next cycle, with no `ready` and `result` unchanged.
- `kill` together with `start` in IDLE: `kill` wins and the start is dropped.
- `rst` mid-operation: return to reset values next cycle. No `ready` is issued.

## Timing

- Accept at the edge ending cycle t. `busy`=1 from cycle t+1.
- MUL-class: `ready` in cycle t+18 (17 iterations plus DONE).
- DIV-class: `ready` in cycle t+33.
- Special-case divide: `ready` in cycle t+1.
- `busy` falls in the cycle after `ready`. The earliest next accept is the cycle after `ready`.
- No combinational path from inputs to outputs. All outputs are registered.

## Configuration

- `MULDIV_DIV_EN` defined: divider, DIV state and special-case logic are compiled in.
- `MULDIV_DIV_EN` undefined: DIV-class ops still take the DONE path, with `ready` at t+1 and `result` = 0. The MUL path is unchanged.

## Structure

- `muldiv_pkg` contains:
  - `muldiv_op_e`, the funct3 encoding.
  - `muldiv_state_e`.
  - `MUL_ITERS`=17 and `DIV_ITERS`=32.
  - The special-case constants `DIV0_Q`=32'hFFFFFFFF and `OVF_Q`=32'h80000000.
- Sub-module `booth_r4_enc`: combinational recoder.
  - Input: a 3-bit multiplier window.
  - Output: partial-product select (0, ±1, ±2 × multiplicand).
  - Instantiated once; the iteration counter selects the window.

## Test plan

- MUL 7 × 0xFFFFFFFD (−3), start at t → `ready` at t+18, `result`=0xFFFFFFEB, `waddr_out` matches the captured destination.
- Upper-half variants:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFEC (−20) / 3 → 0xFFFFFFFA at t+33; REM on the same operands → 0xFFFFFFFE.
- Special cases:
  - DIVU 5 / 0 → 0xFFFFFFFF at t+1.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at t+1.
- MUL started at t, `kill` at t+5 → `busy`=0 at t+6, no `ready` ever issued, then a new start is accepted and completes normally.
- `start` pulsed while `busy` → ignored, and the first result is unaffected. With `MULDIV_DIV_EN` undefined, DIV → `result`=0 at t+1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Divider support is compiled in only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam int MUL_ITERS = 17;
    localparam int DIV_ITERS = 32;

    localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_Q  = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } muldiv_state_e;

    typedef enum logic [2:0] {
        PP_ZERO,
        PP_POS1,
        PP_NEG1,
        PP_POS2,
        PP_NEG2
    } booth_sel_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EXE stage (master) and muldiv_unit (slave).
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      waddr_in;
    logic            busy;
    logic            ready;
    logic [XLEN-1:0] result;
    logic [4:0]      waddr_out;

    modport master (
        output start, kill, op, rs1, rs2, waddr_in,
        input  busy, ready, result, waddr_out
    );

    modport slave (
        input  start, kill, op, rs1, rs2, waddr_in,
        output busy, ready, result, waddr_out
    );
endinterface

// File: rtl/muldiv_booth_r4_enc.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to a partial-product select.
module booth_r4_enc
    import muldiv_pkg::*;
(
    input  logic [2:0] window,
    output booth_sel_e sel
);

    always_comb begin
        sel = PP_ZERO;
        case (window)
            3'b001, 3'b010: sel = PP_POS1;
            3'b011:         sel = PP_POS2;
            3'b100:         sel = PP_NEG2;
            3'b101, 3'b110: sel = PP_NEG1;
            default:        sel = PP_ZERO;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execute unit: radix-4 Booth multiplier plus a restoring divider
// that is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    localparam int MW = XLEN + 2;
    localparam int PW = 2 * MW;

    muldiv_state_e   state_q, state_d;
    muldiv_op_e      op_q;
    logic [4:0]      cnt_q;
    logic            busy_q, ready_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      waddr_q;

    logic [MW-1:0]   mcand_q;
    logic [MW:0]     mplr_q;
    logic [PW-1:0]   prod_q;

    logic            accept, is_mul;
    logic [MW-1:0]   mcand_in;
    logic [MW:0]     mplr_in;
    logic [2:0]      window;
    booth_sel_e      pp_sel;
    logic [PW-1:0]   mcand_ext, pp, prod_d;
    logic [XLEN-1:0] mul_res;

    assign accept = (state_q == ST_IDLE) && bus.start && !bus.kill;
    assign is_mul = !bus.op[2];

    // MULHU keeps rs1 unsigned; only MUL/MULH (op[1]=0) treat rs2 as signed.
    assign mcand_in = {{2{(bus.op != OP_MULHU) & bus.rs1[XLEN-1]}}, bus.rs1};
    assign mplr_in  = {{2{~bus.op[1] & bus.rs2[XLEN-1]}}, bus.rs2, 1'b0};

    assign window = mplr_q[{cnt_q, 1'b0} +: 3];

    booth_r4_enc u_enc (
        .window (window),
        .sel    (pp_sel)
    );

    always_comb begin
        mcand_ext = {{(PW-MW){mcand_q[MW-1]}}, mcand_q};
        pp        = '0;
        case (pp_sel)
            PP_POS1: pp = mcand_ext;
            PP_NEG1: pp = -mcand_ext;
            PP_POS2: pp = mcand_ext << 1;
            PP_NEG2: pp = -(mcand_ext << 1);
            default: pp = '0;
        endcase
        prod_d  = prod_q + (pp << {cnt_q, 1'b0});
        mul_res = (op_q == OP_MUL) ? prod_d[XLEN-1:0] : prod_d[2*XLEN-1:XLEN];
    end

`ifdef MULDIV_DIV_EN
    logic            signed_div, div0, ovf;
    logic [XLEN-1:0] special_res, dvd_mag, dvs_mag;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q, quo_d, rem_d, div_res;
    logic            neg_quo_q, neg_rem_q;
    logic [XLEN:0]   sh;
    logic            ge;

    assign signed_div = bus.op[2] & ~bus.op[0];
    assign div0       = (bus.rs2 == '0);
    assign ovf        = signed_div && (bus.rs1 == OVF_Q) && (&bus.rs2);

    // op[1] distinguishes REM/REMU from DIV/DIVU in both special and normal results.
    always_comb begin
        special_res = '0;
        if (div0)
            special_res = bus.op[1] ? bus.rs1 : DIV0_Q;
        else
            special_res = bus.op[1] ? '0 : OVF_Q;
        dvd_mag = (signed_div && bus.rs1[XLEN-1]) ? -bus.rs1 : bus.rs1;
        dvs_mag = (signed_div && bus.rs2[XLEN-1]) ? -bus.rs2 : bus.rs2;
        sh      = {rem_q, quo_q[XLEN-1]};
        ge      = (sh >= {1'b0, dvs_q});
        rem_d   = ge ? (sh[XLEN-1:0] - dvs_q) : sh[XLEN-1:0];
        quo_d   = {quo_q[XLEN-2:0], ge};
        div_res = op_q[1] ? (neg_rem_q ? -rem_d : rem_d)
                          : (neg_quo_q ? -quo_d : quo_d);
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul)
                        state_d = ST_MUL;
`ifdef MULDIV_DIV_EN
                    else if (div0 || ovf)
                        state_d = ST_DONE;
                    else
                        state_d = ST_DIV;
`else
                    else
                        state_d = ST_DONE;
`endif
                end
            end
            ST_MUL:  if (cnt_q == 5'(MUL_ITERS - 1)) state_d = ST_DONE;
`ifdef MULDIV_DIV_EN
            ST_DIV:  if (cnt_q == 5'(DIV_ITERS - 1)) state_d = ST_DONE;
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.kill)
            state_d = ST_IDLE;
    end

    // Results load only on the way into DONE, so a kill leaves result untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MUL;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= '0;
            waddr_q   <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            prod_q    <= '0;
`ifdef MULDIV_DIV_EN
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            ready_q <= (state_d == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= muldiv_op_e'(bus.op);
                        waddr_q <= bus.waddr_in;
                        cnt_q   <= '0;
                        prod_q  <= '0;
                        mcand_q <= mcand_in;
                        mplr_q  <= mplr_in;
`ifdef MULDIV_DIV_EN
                        quo_q     <= dvd_mag;
                        rem_q     <= '0;
                        dvs_q     <= dvs_mag;
                        neg_quo_q <= signed_div & (bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1]);
                        neg_rem_q <= signed_div & bus.rs1[XLEN-1];
                        if (state_d == ST_DONE) result_q <= special_res;
`else
                        if (state_d == ST_DONE) result_q <= '0;
`endif
                    end
                end
                ST_MUL: begin
                    cnt_q  <= cnt_q + 5'd1;
                    prod_q <= prod_d;
                    if (state_d == ST_DONE) result_q <= mul_res;
                end
`ifdef MULDIV_DIV_EN
                ST_DIV: begin
                    cnt_q <= cnt_q + 5'd1;
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    if (state_d == ST_DONE) result_q <= div_res;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.ready     = ready_q;
    assign bus.result    = result_q;
    assign bus.waddr_out = waddr_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against an
// arithmetic reference model; expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] last_exp    = 32'd0;

    function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          ia, ib;
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); return p[31:0]; end
            3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
            3'd2: begin p = longint'($signed(a)) * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            default: ;
        endcase
`ifdef MULDIV_DIV_EN
        case (op)
            3'd4: if (b == 0) return 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                  else return 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: if (b == 0) return a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                  else return 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
`else
        return 32'd0;
`endif
    endfunction

    function automatic int model_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 18;
`ifdef MULDIV_DIV_EN
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
`else
        return 1;
`endif
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One full operation; poke_cycle>0 re-pulses start with junk operands mid-flight.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] wa, input int poke_cycle, input string tag);
        int          cyc;
        int          exp_lat;
        logic [31:0] exp_res;
        exp_res = model_result(op, a, b);
        exp_lat = model_latency(op, a, b);
        @(negedge clk);
        bus.op       = op;
        bus.rs1      = a;
        bus.rs2      = b;
        bus.waddr_in = wa;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc       = 1;
        checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd1);
        while (!bus.ready && cyc < 40) begin
            if (cyc == poke_cycle) begin
                bus.start    = 1'b1;
                bus.op       = ~op;
                bus.rs1      = ~a;
                bus.rs2      = 32'd1;
                bus.waddr_in = ~wa;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        checkOutput({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
        checkOutput({tag, ".result"}, bus.result, exp_res);
        checkOutput({tag, ".waddr"}, 32'(bus.waddr_out), 32'(wa));
        @(negedge clk);
        checkOutput({tag, ".idle"}, {30'd0, bus.busy, bus.ready}, 32'd0);
        last_exp = exp_res;
    endtask

    task automatic killTest();
        int pulses;
        @(negedge clk);
        bus.op       = 3'd0;
        bus.rs1      = 32'd1234;
        bus.rs2      = 32'd5678;
        bus.waddr_in = 5'd9;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        checkOutput("kill.busy", 32'(bus.busy), 32'd0);
        pulses = 0;
        repeat (25) begin
            if (bus.ready) pulses++;
            @(negedge clk);
        end
        checkOutput("kill.no_ready", 32'(pulses), 32'd0);
        checkOutput("kill.result_kept", bus.result, last_exp);
    endtask

    task automatic resetMidOpTest();
        int pulses;
        @(negedge clk);
        bus.op       = 3'd1;
        bus.rs1      = 32'h1234_5678;
        bus.rs2      = 32'h9ABC_DEF0;
        bus.waddr_in = 5'd17;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mid.outputs", {bus.waddr_out, 25'd0, bus.busy, bus.ready}, 32'd0);
        checkOutput("rst_mid.result", bus.result, 32'd0);
        pulses = 0;
        repeat (25) begin
            if (bus.ready) pulses++;
            @(negedge clk);
        end
        checkOutput("rst_mid.no_ready", 32'(pulses), 32'd0);
        last_exp = 32'd0;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.kill     = 1'b0;
        bus.op       = 3'd0;
        bus.rs1      = 32'd0;
        bus.rs2      = 32'd0;
        bus.waddr_in = 5'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset.flags", {30'd0, bus.busy, bus.ready}, 32'd0);
        checkOutput("reset.result", bus.result, 32'd0);
        checkOutput("reset.waddr", 32'(bus.waddr_out), 32'd0);
        rst = 1'b0;
        $display("[TB] reset released");

        applyStimulus(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  0, "mul_7_m3");
        applyStimulus(3'd1, 32'h8000_0000,  32'h8000_0000, 5'd6,  0, "mulh_min");
        applyStimulus(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  0, "mulhu_max");
        applyStimulus(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  0, "mulhsu_max");
        applyStimulus(3'd4, 32'hFFFF_FFEC,  32'd3,         5'd10, 0, "div_m20_3");
        applyStimulus(3'd6, 32'hFFFF_FFEC,  32'd3,         5'd11, 0, "rem_m20_3");
        applyStimulus(3'd5, 32'd5,          32'd0,         5'd12, 0, "divu_by0");
        applyStimulus(3'd7, 32'd5,          32'd0,         5'd13, 0, "remu_by0");
        applyStimulus(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 0, "div_ovf");
        applyStimulus(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 0, "rem_ovf");

        killTest();
        applyStimulus(3'd0, 32'd100,        32'd200,       5'd20, 0, "after_kill");
        applyStimulus(3'd0, 32'hDEAD_BEEF,  32'h0000_1001, 5'd21, 3, "start_while_busy");
        resetMidOpTest();
        applyStimulus(3'd3, 32'h0001_0000,  32'h0001_0000, 5'd22, 0, "after_reset");

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = rand_operand();
            rb  = rand_operand();
            applyStimulus(rop, ra, rb, 5'($urandom_range(0, 31)), 0, $sformatf("rand%0d_op%0d", i, rop));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
